// File: rtl/dcache_port_responder.sv
// dcache_port_responder
//
// Cache-side responder for the two-phase dcache request protocol. Loads and
// stores are served from a local scratchpad of 64-bit words. Load data
// returns a fixed number of cycles after the tag cycle.
//
// Each access moves through these steps:
//   request phase: a grant captures the index and the write payload.
//   tag phase: the next cycle supplies the tag, then the access is
//              performed or dropped.
//   load pipeline: loads then travel through a Latency-deep pipeline to
//                  data_rvalid.
// A new grant may overlap the tag phase of the previous access, so back-to-back
// accesses sustain one per cycle.
//
// Parameters:
//   MemWords : scratchpad depth in 64-bit words (power of two, 16..65536)
//   Latency  : cycles from tag cycle to data_rvalid (1..4)
//   BaseAddr : byte base of the scratchpad, aligned to MemWords*8
//
// Ports:
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   req_port_i  : request from the initiator (dcache_req_i_t)
//   req_port_o  : data_gnt / data_rvalid / data_rdata (dcache_req_o_t)
//   gnt_stall_i : forces data_gnt low this cycle
//   err_o       : one-cycle pulse on a protocol or range error

package dcache_port_responder_pkg;

  localparam int unsigned IndexWidth = 12;
  localparam int unsigned TagWidth   = 44;

  typedef struct packed {
    logic [IndexWidth-1:0] address_index;
    logic [TagWidth-1:0]   address_tag;
    logic [63:0]           data_wdata;
    logic                  data_req;
    logic                  data_we;
    logic [7:0]            data_be;
    logic [1:0]            data_size;
    logic                  kill_req;
    logic                  tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

module dcache_port_responder
  import dcache_port_responder_pkg::*;
#(
  parameter int unsigned MemWords = 1024,
  parameter int unsigned Latency  = 1,
  parameter logic [63:0] BaseAddr = 64'h8000_0000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t req_port_i,
  output dcache_req_o_t req_port_o,
  input  logic          gnt_stall_i,
  output logic          err_o
);

  localparam int unsigned WordAw  = $clog2(MemWords);
  localparam logic [63:0] EndAddr = BaseAddr + 64'(MemWords) * 64'd8;

  // Request phase
  logic gnt;
  assign gnt = req_port_i.data_req & ~gnt_stall_i;

  logic                  tag_pend_q;
  logic [IndexWidth-1:0] idx_q;
  logic                  we_q;
  logic [63:0]           wdata_q;
  logic [7:0]            be_q;

  // A grant in the tag cycle re-arms tag_pend, which lets accesses overlap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag_pend_q <= 1'b0;
    end else begin
      tag_pend_q <= gnt;
    end
  end

  // The payload registers need no reset. They are only consumed while
  // tag_pend_q is set.
  always_ff @(posedge clk_i) begin
    if (rst_ni && gnt) begin
      idx_q   <= req_port_i.address_index;
      we_q    <= req_port_i.data_we;
      wdata_q <= req_port_i.data_wdata;
      be_q    <= req_port_i.data_be;
    end
  end

  // Tag phase
  logic [63:0]        mem_q [MemWords];
  logic [63:0]        tag_addr;
  logic               in_range;
  logic [WordAw-1:0]  word_sel;
  logic               do_write;
  logic               do_push;
  logic [63:0]        push_data;
  logic               err;

  assign tag_addr = 64'({req_port_i.address_tag, idx_q});
  assign in_range = (tag_addr >= BaseAddr) && (tag_addr < EndAddr);
  // BaseAddr is aligned to the scratchpad size, so the low address bits index it directly.
  assign word_sel = tag_addr[3 +: WordAw];

  always_comb begin
    do_write  = 1'b0;
    do_push   = 1'b0;
    push_data = '0;
    err       = 1'b0;
    // A killed access is dropped silently, whatever tag_valid says.
    if (rst_ni && tag_pend_q && !req_port_i.kill_req) begin
      if (!req_port_i.tag_valid) begin
        err = 1'b1;
      end else if (!in_range) begin
        // An out-of-range load still completes, with zero data, so the initiator does not hang.
        err     = 1'b1;
        do_push = ~we_q;
      end else if (we_q) begin
        do_write = 1'b1;
      end else begin
        do_push   = 1'b1;
        push_data = mem_q[word_sel];
      end
    end
  end

  // Scratchpad is not reset. A store in cycle T is visible to a load tagged in T+1.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (be_q[b]) begin
          mem_q[word_sel][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Load return pipeline
  // Invalid stages carry zero data, so rdata stays zero whenever rvalid is low.
  logic [Latency-1:0] pipe_valid_q;
  logic [63:0]        pipe_data_q [Latency];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid_q <= '0;
      for (int unsigned i = 0; i < Latency; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= do_push;
      pipe_data_q[0]  <= push_data;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  // Outputs
  logic rvalid;
  assign rvalid = rst_ni & pipe_valid_q[Latency-1];

  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = gnt;
    req_port_o.data_rvalid = rvalid;
    req_port_o.data_rdata  = rvalid ? pipe_data_q[Latency-1] : 64'h0;
  end

  assign err_o = err;

  // The access size is irrelevant: reads always return the full aligned word.
  logic unused_size;
  assign unused_size = ^req_port_i.data_size;

endmodule

// File: tb/tb_dcache_port_responder.sv
// Testbench for dcache_port_responder.
// The bench drives three instances, with Latency 1, 3 and 4, from the same
// stimulus. A reference model works at the transaction level. It keeps a
// word-array memory and a table of expected responses indexed by cycle, and
// all three instances are checked against it on every falling clock edge.
module tb_dcache_port_responder;
  import dcache_port_responder_pkg::*;

  localparam int unsigned MemWords = 64;
  localparam logic [63:0] Base     = 64'h8000_0000;
  localparam logic [63:0] EndA     = Base + 64'(MemWords) * 64'd8;
  localparam int          NDut     = 3;
  localparam int          Depth    = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  dcache_req_i_t req;
  dcache_req_o_t rsp [NDut];
  logic          err [NDut];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    dcache_port_responder #(
      .MemWords(MemWords),
      .Latency (L),
      .BaseAddr(Base)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_port_i (req),
      .req_port_o (rsp[g]),
      .gnt_stall_i(stall),
      .err_o      (err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  bit          exp_v [NDut][Depth];
  logic [63:0] exp_d [NDut][Depth];
  logic [63:0] model_mem [MemWords];
  bit          m_pend = 1'b0;
  logic [63:0] m_addr, m_wdata;
  bit          m_we;
  logic [7:0]  m_be;
  logic [63:0] last_rdata [NDut];
  int          rvalid_cnt [NDut];
  int          err_cnt [NDut];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic schedule(input logic [63:0] d);
    for (int k = 0; k < NDut; k++) begin
      exp_v[k][cyc+lat_of(k)] = 1'b1;
      exp_d[k][cyc+lat_of(k)] = d;
    end
  endtask

  // One clock cycle. The request fields describe a new request. tv and kill
  // apply to the tag phase of the previous grant, if there is one.
  task automatic step(input bit rq, input bit we, input logic [63:0] addr,
                      input logic [63:0] wd, input logic [7:0] be, input bit stl,
                      input bit tv, input bit kill, input bit rn);
    bit          exp_gnt, exp_err, in_rng, ev;
    logic [63:0] ed;
    int          w;
    req.data_req      = rq;
    req.data_we       = we;
    req.address_index = addr[11:0];
    req.data_wdata    = wd;
    req.data_be       = be;
    req.data_size     = 2'($urandom);
    req.address_tag   = m_pend ? m_addr[55:12] : 44'({$urandom, $urandom});
    req.tag_valid     = tv;
    req.kill_req      = kill;
    stall             = stl;
    rst_n             = rn;
    @(negedge clk);
    exp_gnt = rq & ~stl;
    exp_err = 1'b0;
    if (rn && m_pend && !kill) begin
      if (!tv) begin
        exp_err = 1'b1;
      end else begin
        in_rng = (m_addr >= Base) && (m_addr < EndA);
        w = int'((m_addr - Base) >> 3);
        if (!in_rng) begin
          exp_err = 1'b1;
          if (!m_we) schedule(64'h0);
        end else if (m_we) begin
          for (int b = 0; b < 8; b++) begin
            if (m_be[b]) model_mem[w][8*b +: 8] = m_wdata[8*b +: 8];
          end
        end else begin
          schedule(model_mem[w]);
        end
      end
    end
    for (int k = 0; k < NDut; k++) begin
      ev = rn && exp_v[k][cyc];
      ed = ev ? exp_d[k][cyc] : 64'h0;
      check($sformatf("gnt[%0d]@%0d", k, cyc), 64'(rsp[k].data_gnt), 64'(exp_gnt));
      check($sformatf("err[%0d]@%0d", k, cyc), 64'(err[k]), 64'(exp_err));
      check($sformatf("rvalid[%0d]@%0d", k, cyc), 64'(rsp[k].data_rvalid), 64'(ev));
      check($sformatf("rdata[%0d]@%0d", k, cyc), rsp[k].data_rdata, ed);
      if (rsp[k].data_rvalid) begin
        last_rdata[k] = rsp[k].data_rdata;
        rvalid_cnt[k]++;
      end
      if (err[k]) err_cnt[k]++;
    end
    if (!rn) begin
      for (int k = 0; k < NDut; k++) begin
        for (int j = 1; j <= 8; j++) exp_v[k][cyc+j] = 1'b0;
      end
    end
    m_pend = rn & exp_gnt;
    if (m_pend) begin
      m_addr  = addr;
      m_we    = we;
      m_wdata = wd;
      m_be    = be;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, Base, 64'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic st(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    step(1'b1, 1'b1, a, d, be, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic ld(input logic [63:0] a);
    step(1'b1, 1'b0, a, 64'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          rv0 [NDut];
    int          er0 [NDut];
    logic [63:0] a;
    bit          rq, we, stl, tv, kill;
    int          r;

    for (int k = 0; k < NDut; k++) begin
      rvalid_cnt[k] = 0;
      err_cnt[k]    = 0;
      last_rdata[k] = 64'h0;
      for (int j = 0; j < Depth; j++) exp_v[k][j] = 1'b0;
    end
    req = '0;
    stall = 1'b0;
    rst_n = 1'b0;

    // Reset state; gnt still follows the request while in reset.
    repeat (2) step(1'b0, 1'b0, Base, 64'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, Base, 64'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill the whole scratchpad, back to back.
    for (int i = 0; i < int'(MemWords); i++) begin
      st(Base + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
    end
    idle(1);

    // Store then load, read-after-write in consecutive tag cycles.
    st(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    ld(64'h8000_0010);
    idle(6);
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("raw_data[%0d]", k), last_rdata[k], 64'h1122_3344_5566_7788);
    end

    // Partial byte enables.
    st(64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    st(64'h8000_0020, 64'h0, 8'h0F);
    ld(64'h8000_0020);
    idle(6);
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("be_data[%0d]", k), last_rdata[k], 64'hFFFF_FFFF_0000_0000);
    end

    // Back-to-back loads, returned in order.
    for (int k = 0; k < NDut; k++) rv0[k] = rvalid_cnt[k];
    ld(64'h8000_0020);
    ld(64'h8000_0018);
    ld(64'h8000_0010);
    idle(6);
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("b2b_count[%0d]", k), 64'(rvalid_cnt[k] - rv0[k]), 64'd3);
      check($sformatf("b2b_last[%0d]", k), last_rdata[k], 64'h1122_3344_5566_7788);
    end

    // Grant backpressure for three cycles, then release.
    repeat (3) step(1'b1, 1'b0, 64'h8000_0008, 64'h0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    ld(64'h8000_0008);
    idle(6);

    // Killed in the tag cycle: no response and no error.
    for (int k = 0; k < NDut; k++) begin
      rv0[k] = rvalid_cnt[k];
      er0[k] = err_cnt[k];
    end
    ld(64'h8000_0018);
    step(1'b0, 1'b0, Base, 64'h0, 8'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(6);
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("kill_rvalid[%0d]", k), 64'(rvalid_cnt[k] - rv0[k]), 64'd0);
      check($sformatf("kill_err[%0d]", k), 64'(err_cnt[k] - er0[k]), 64'd0);
    end

    // Out-of-range load returns zero with an error pulse.
    for (int k = 0; k < NDut; k++) begin
      rv0[k] = rvalid_cnt[k];
      er0[k] = err_cnt[k];
    end
    ld(64'h0000_1000);
    idle(6);
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("oor_rvalid[%0d]", k), 64'(rvalid_cnt[k] - rv0[k]), 64'd1);
      check($sformatf("oor_err[%0d]", k), 64'(err_cnt[k] - er0[k]), 64'd1);
      check($sformatf("oor_data[%0d]", k), last_rdata[k], 64'h0);
    end

    // Missing tag_valid: error, no response.
    ld(Base);
    step(1'b0, 1'b0, Base, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);

    // A store just past the end must not alias word 0.
    st(EndA, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    st(Base - 64'd8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    ld(Base);
    idle(6);
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("no_alias[%0d]", k), last_rdata[k], model_mem[0]);
    end

    // Reset one cycle after the tag cycle discards the in-flight load.
    for (int k = 0; k < NDut; k++) rv0[k] = rvalid_cnt[k];
    ld(64'h8000_0030);
    idle(1);
    repeat (2) step(1'b0, 1'b0, Base, 64'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    check("rst_discard_lat4", 64'(rvalid_cnt[2] - rv0[2]), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rq   = ($urandom_range(0, 9) < 8);
      we   = ($urandom_range(0, 9) < 4);
      stl  = ($urandom_range(0, 4) == 0);
      tv   = ($urandom_range(0, 19) != 0);
      kill = tv && ($urandom_range(0, 19) == 0);
      r    = int'($urandom_range(0, 11));
      if (r == 0) a = 64'h0000_1000;
      else if (r == 1) a = EndA + 64'($urandom_range(0, 63));
      else if (r == 2) a = Base - 64'd8 + 64'($urandom_range(0, 7));
      else a = Base + 64'(8 * $urandom_range(0, MemWords - 1)) + 64'($urandom_range(0, 7));
      step(rq, we, a, {$urandom, $urandom}, 8'($urandom), stl, tv, kill, 1'b1);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
